// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path definitions: the header macros plus typed equivalents
// and the FIFO entry layout used by inst_fetch and fetch_fifo.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define Inst_Addr    31:0
`define Inst_Data    31:0
`define Chip_Enable  1'b1
`define Chip_Disable 1'b0
`define Zero_Word    32'h0000_0000
`define Rst_Enable   1'b0
`define Pc_Step      32'd4
`endif

package inst_fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic CHIP_ENABLE  = `Chip_Enable;
  localparam logic CHIP_DISABLE = `Chip_Disable;
  localparam logic RST_ENABLE   = `Rst_Enable;

  localparam logic [ADDR_W-1:0] PC_STEP   = `Pc_Step;
  localparam logic [DATA_W-1:0] ZERO_WORD = `Zero_Word;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Branch targets are forced onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding {pc, inst} pairs between fetch and decode.
// Flush clears the pointers and count and wins over push and pop.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && rst != RST_ENABLE) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/inst_fetch.sv
// Fetch front end: PC and ROM chip-enable registers, push/branch arbitration,
// and the fetch FIFO that feeds decode over a valid/ready handshake.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);
  // Handshake: an entry transfers to decode on any rising edge where
  // id_valid_o && id_ready_i; id_valid_o never depends on id_ready_i.
  logic [31:0]  pc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  assign pop      = id_valid_o && id_ready_i;
  assign push     = (rom_ce_o == CHIP_ENABLE) && !stall_i && !branch_flag_i && (!full || pop);
  assign wr_entry = '{pc: pc, inst: rom_inst_i};

  // rom_ce_o doubles as the reset/run state: disabled only while in reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc       <= RESET_PC;
      rom_ce_o <= CHIP_DISABLE;
    end else begin
      rom_ce_o <= CHIP_ENABLE;
      if (branch_flag_i)
        pc <= word_align(branch_target_i);
      else if (push)
        pc <= pc + PC_STEP;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_flag_i),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty)
  );

  assign rom_addr_o = pc;
  assign id_valid_o = !empty;
  assign id_pc_o    = rd_entry.pc;
  assign id_inst_o  = empty ? ZERO_WORD : rd_entry.inst;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized phase, checked by
// a queue-based reference model and a negedge monitor.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state: expected FIFO contents as {pc, inst}.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc  = RESET_PC;
  logic        m_ce  = 1'b0;
  int          m_cnt = 0;

  inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, pushes follow the fetch rules.
  always @(posedge clk) begin : model
    bit pop_m;
    bit push_m;
    pop_m  = (m_cnt > 0) && id_ready_i;
    push_m = 1'b0;
    if (!rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_pc  = RESET_PC;
      m_ce  = 1'b0;
    end else if (branch_flag_i) begin
      exp_q.delete();
      m_cnt = 0;
      m_pc  = {branch_target_i[31:2], 2'b00};
      m_ce  = 1'b1;
    end else begin
      push_m = m_ce && !stall_i && ((m_cnt < DEPTH) || pop_m);
      m_cnt  = m_cnt - int'(pop_m) + int'(push_m);
      if (push_m) begin
        exp_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_ce = 1'b1;
    end
  end

  // Monitor: compares DUT outputs with the model, pops on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [63:0] head;
      check("rom_ce", {31'b0, rom_ce_o}, {31'b0, m_ce});
      check("rom_addr", rom_addr_o, m_pc);
      check("id_valid", {31'b0, id_valid_o}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() == 0) begin
        check("id_pc_empty", id_pc_o, 32'h0);
        check("id_inst_empty", id_inst_o, 32'h0);
      end else begin
        head = exp_q[0];
        check("id_pc", id_pc_o, head[63:32]);
        check("id_inst", id_inst_o, head[31:0]);
        if (id_valid_o && id_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic br,
                       input logic [31:0] tgt, input logic rdy);
    rst             = r;
    stall_i         = st;
    branch_flag_i   = br;
    branch_target_i = tgt;
    id_ready_i      = rdy;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(3);
    mon_en = 1'b1;
    check("reset_ce", {31'b0, rom_ce_o}, 32'h0);
    check("reset_valid", {31'b0, id_valid_o}, 32'h0);
    check("reset_addr", rom_addr_o, RESET_PC);

    // Free run from reset
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1);
    check("ce_after_release", {31'b0, rom_ce_o}, 32'h1);
    cyc(10);

    // Backpressure from empty at pc 0
    drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(5);
    check("bp_addr", rom_addr_o, 32'h8);
    check("bp_head", id_pc_o, 32'h0);
    id_ready_i = 1'b1;
    cyc(6);

    // Stall at pc 0x10
    drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b1);
    cyc(1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("stall_addr", rom_addr_o, 32'h10);
    end
    stall_i = 1'b0;
    cyc(1);
    check("stall_release_head", id_pc_o, 32'h10);
    cyc(3);

    // Branch with entries queued and stall asserted, unaligned target
    id_ready_i = 1'b0;
    cyc(3);
    drive(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
    cyc(1);
    check("br_valid", {31'b0, id_valid_o}, 32'h0);
    check("br_addr", rom_addr_o, 32'h200);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1);
    check("br_head_pc", id_pc_o, 32'h200);
    check("br_head_inst", id_inst_o, 32'h1000_0080);
    cyc(3);

    // PC wrap
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cyc(1);
    check("wrap_addr0", rom_addr_o, 32'hFFFF_FFFC);
    branch_flag_i = 1'b0;
    cyc(1);
    check("wrap_addr1", rom_addr_o, 32'h0);
    cyc(4);

    // Reset while full
    id_ready_i = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    check("mid_rst_valid", {31'b0, id_valid_o}, 32'h0);
    check("mid_rst_ce", {31'b0, rom_ce_o}, 32'h0);
    check("mid_rst_addr", rom_addr_o, RESET_PC);
    check("mid_rst_pc", id_pc_o, 32'h0);
    check("mid_rst_inst", id_inst_o, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1);
    check("mid_rst_ce_on", {31'b0, rom_ce_o}, 32'h1);
    cyc(1);
    check("mid_rst_first", id_pc_o, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) >= 2,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 8,
            $urandom(),
            $urandom_range(0, 99) < 70);
      cyc(1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end that drives the combinational instruction ROM and delivers fetched words to the decode stage. It holds the program counter and raises the ROM chip enable. Each returned word is captured, together with its PC, into a small FIFO that presents a valid/ready interface to decode. The block sits between the pipeline control logic (stall, branch redirect) and the ID stage, and is the requesting side of the ROM interface.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, fetch FIFO entries; must be a power of two, ≥2.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset: one clock; reset is synchronous and active-low.
- stall_i  input  1  1 = hold PC and suppress new fetches.
- branch_flag_i  input  1  1 = redirect fetch to branch_target_i this cycle.
- branch_target_i  input  `Inst_Addr  redirect address.
- rom_ce_o  output  1  ROM chip enable (`Chip_Enable / `Chip_Disable).
- rom_addr_o  output  `Inst_Addr  byte address to ROM; equals PC.
- rom_inst_i  input  `Inst_Data  ROM data, combinational from rom_addr_o.
- id_valid_o  output  1  FIFO head is valid.
- id_ready_i  input  1  decode accepts head this cycle.
- id_pc_o  output  `Inst_Addr  PC of head entry.
- id_inst_o  output  `Inst_Data  instruction of head entry.

## Operation
- Reset (rst=0 at edge): pc=RESET_PC, rom_ce_o=0, FIFO count=0, id_valid_o=0, id_pc_o=0, id_inst_o=`Zero_Word.
- rom_ce_o is a register: 0 while in reset, 1 from the first edge after rst=1.
- Push: rom_ce_o=1, stall_i=0, branch_flag_i=0, and slot available, i.e. count<DEPTH or pop in the same cycle. Writes {pc, rom_inst_i} at the tail, then pc<=pc+4.
- Pop: id_valid_o && id_ready_i. The head advances.
- Full FIFO with simultaneous pop accepts a push; count unchanged.
- stall_i=1: no push and PC held; pops continue.
- branch_flag_i=1 has top priority:
  - FIFO flushed (count<=0, pointers reset), including any entry popped that cycle.
  - pc <= {branch_target_i[31:2], 2'b00}.
  - No push that cycle.
  - Branch overrides stall.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
- id_valid_o = (count != 0). id_pc_o and id_inst_o show the head entry and are zero when empty.
- No state machine beyond the reset/run state carried by rom_ce_o. Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- rom_addr_o = pc register, stable for the whole cycle. The ROM answers combinationally in the same cycle.
- Fetch latency: address presented in cycle N -> entry visible (id_valid_o=1) in cycle N+1.
- Redirect latency: branch_flag_i in cycle N -> target on rom_addr_o in N+1 -> target instruction at head in N+2. id_valid_o=0 in N+1.
- Throughput: one instruction per cycle while id_ready_i=1 and stall_i=0.
- id_ready_i may be asserted with id_valid_o=0; this has no effect.
- A mid-operation reset discards FIFO contents and redirect state on that edge. Fetch resumes at RESET_PC one cycle after rst returns to 1.

## Structure
- Shared header define.v holds `Inst_Addr, `Inst_Data, `Chip_Enable, `Chip_Disable, `Zero_Word, `Rst_Enable (1'b0), and the PC increment constant.
- One sub-module: fetch_fifo (parameter DEPTH). It has push/pop/flush inputs, full/empty outputs and a data width of `Inst_Addr+`Inst_Data.
- inst_fetch contains the PC register, ce register and push/branch arbitration.

## Test plan
- Reset then free run, ROM word i = 32'h1000_0000+i, id_ready_i=1 → rom_ce_o rises one cycle after release. id_pc_o/id_inst_o step 0/32'h1000_0000, 4/32'h1000_0001, ... with one entry per cycle.
- Backpressure: id_ready_i=0 for 5 cycles from empty → exactly DEPTH=2 entries (pc 0, 4) are held, rom_addr_o stalls at 8. On release, 0, 4, 8 are delivered in order with no loss or duplicate.
- stall_i=1 for 3 cycles at pc=0x10 → rom_addr_o stays 0x10 and no push occurs. The entry for 0x10 appears the cycle after stall_i drops.
- Branch to 0x200 with 2 entries queued and stall_i=1 → id_valid_o=0 next cycle and rom_addr_o=0x200. Head becomes pc 0x200 one cycle later. Target 0x203 yields 0x200.
- Wrap: branch to 0xFFFF_FFFC → entries 0xFFFF_FFFC then 0x0000_0000.
- rst=0 asserted while FIFO is full → outputs return to reset values at that edge. First entry after release is RESET_PC.
